// File: rtl/mole_pkg.sv
// Shared types and constants for the mole game: button count, game state codes,
// and the press event payload passed from the input stage to the game FSM.
package mole_pkg;

    localparam int unsigned MOLE_N_BTN  = 4;
    localparam int unsigned MOLE_IDX_W  = (MOLE_N_BTN > 1) ? $clog2(MOLE_N_BTN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_MISS      = 3'd4,
        ST_CLEAR     = 3'd5
    } game_state_e;

    typedef struct packed {
        logic                  multi;
        logic [MOLE_IDX_W-1:0] idx;
    } press_evt_t;

    localparam int unsigned PRESS_EVT_W = $bits(press_evt_t);

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, then a stable level that only follows the
// synchronised input after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync  = sync2_q;
    assign level = level_q;

endmodule

// File: rtl/mole_button_input.sv
// Player input front end: debounced button levels, press-edge detection and a
// 1-deep valid/ready event register (lowest index wins, multi flag, sticky overrun).
module mole_button_input
    import mole_pkg::*;
#(
    parameter  int unsigned N_BTN           = MOLE_N_BTN,
    parameter  int unsigned DEBOUNCE_CYCLES = 20000,
    parameter  bit          ACTIVE_LOW      = 1'b0,
    localparam int unsigned IDX_W           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    input  logic             press_ready,
    output logic [N_BTN-1:0] btn_level,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic             press_multi,
    output logic             overrun
);

    logic [N_BTN-1:0] btn_norm;
    logic [N_BTN-1:0] sync_s;
    logic [N_BTN-1:0] level_s;

    assign btn_norm = btn_raw ^ {N_BTN{ACTIVE_LOW}};

    for (genvar g = 0; g < N_BTN; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_norm[g]),
            .sync  (sync_s[g]),
            .level (level_s[g])
        );
    end

    logic [N_BTN-1:0] level_dly_q, level_dly_d;
    logic [N_BTN-1:0] rise_q, rise_d;
    logic [N_BTN-1:0] armed_q, armed_d;
    logic [1:0]       prime_q, prime_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             multi_q, multi_d;
    logic             overrun_q, overrun_d;
    logic [IDX_W-1:0] new_idx;
    logic             new_multi;
    logic             new_ev;

    // A button is armed once it has been seen released after reset, so a button
    // held through reset cannot produce an event until it is re-pressed.
    always_comb begin
        prime_d     = {prime_q[0], 1'b1};
        armed_d     = armed_q | (prime_q[1] ? (~sync_s & ~level_s) : '0);
        level_dly_d = level_s;
        rise_d      = level_s & ~level_dly_q & armed_q;

        new_idx = '0;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (rise_q[i]) new_idx = IDX_W'(i);
        end
        new_multi = |(rise_q & (rise_q - N_BTN'(1)));
        new_ev    = enable && (|rise_q);

        valid_d   = valid_q;
        idx_d     = idx_q;
        multi_d   = multi_q;
        overrun_d = overrun_q;
        if (!enable) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else if (new_ev) begin
            if (!valid_q || press_ready) begin
                valid_d = 1'b1;
                idx_d   = new_idx;
                multi_d = new_multi;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && press_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_q     <= '0;
            armed_q     <= '0;
            level_dly_q <= '0;
            rise_q      <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            multi_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prime_q     <= prime_d;
            armed_q     <= armed_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            multi_q     <= multi_d;
            overrun_q   <= overrun_d;
        end
    end

    assign btn_level   = level_s;
    assign press_valid = valid_q;
    assign press_idx   = idx_q;
    assign press_multi = multi_q;
    assign overrun     = overrun_q;

endmodule
